// File: rtl/hifq_seq_ctrl.sv
// Pointer and burst sequencer for the high-frequency circular sample queue.
// Writes each sample at the head and replays the newest BURST samples, oldest first, to the FIR MAC.
module hifq_seq_ctrl #(
    parameter int unsigned DEPTH = 1536,
    parameter int unsigned AW    = 11,
    parameter int unsigned BURST = 1021
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrt_smpl,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          rd_vld,
    output logic          rd_first,
    output logic          rd_last,
    output logic          sequencing,
    output logic          full,
    output logic          overrun
);

    localparam int unsigned AW1       = AW + 1;
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [AW-1:0] LAST_A   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] BURST_A  = AW'(BURST);
    localparam logic [AW-1:0] BURST_M1 = AW'(BURST - 1);
    localparam logic [AW:0]   BURST_W  = AW1'(BURST);
    localparam logic [AW:0]   DEPTH_W  = AW1'(DEPTH);

    typedef enum logic [1:0] {FILL, IDLE, SEQ, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic          pending_q, pending_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_first_q, rd_first_d;
    logic          rd_last_q, rd_last_d;
    logic          sequencing_q, sequencing_d;
    logic          full_q, full_d;
    logic          overrun_q, overrun_d;
    logic          go_seq;
    logic [AW:0]   ptr_ext;
    logic [AW:0]   start_w;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        raddr_d    = raddr_q;
        cnt_d      = cnt_q;
        rcnt_d     = rcnt_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        rd_vld_d   = 1'b0;
        rd_first_d = 1'b0;
        rd_last_d  = 1'b0;
        go_seq     = 1'b0;

        if (wrt_smpl) begin
            wr_ptr_d = (wr_ptr_q == LAST_A) ? '0 : wr_ptr_q + ONE_A;
            if (cnt_q != BURST_A) cnt_d = cnt_q + ONE_A;
        end

        // Window start from the post-write head, kept non-negative in AW+1 bits
        ptr_ext = {1'b0, wr_ptr_d};
        start_w = (ptr_ext >= BURST_W) ? ptr_ext - BURST_W : ptr_ext + DEPTH_W - BURST_W;

        case (state_q)
            FILL:  if (wrt_smpl && (cnt_d == BURST_A)) go_seq = 1'b1;
            IDLE:  if (wrt_smpl) go_seq = 1'b1;
            SEQ: begin
                rd_vld_d   = 1'b1;
                rd_first_d = (rcnt_q == '0);
                rd_last_d  = (rcnt_q == BURST_M1);
                raddr_d    = (raddr_q == LAST_A) ? '0 : raddr_q + ONE_A;
                rcnt_d     = rcnt_q + ONE_A;
                if (wrt_smpl) begin
                    if (pending_q) overrun_d = 1'b1;
                    pending_d = 1'b1;
                end
                if (rcnt_q == BURST_M1) state_d = DRAIN;
            end
            DRAIN: begin
                pending_d = 1'b0;
                if (pending_q || wrt_smpl) go_seq = 1'b1;
                else                       state_d = IDLE;
            end
            default: state_d = FILL;
        endcase

        if (go_seq) begin
            state_d = SEQ;
            raddr_d = start_w[AW-1:0];
            rcnt_d  = '0;
        end

        sequencing_d = (state_d == SEQ) || (state_d == DRAIN);
        full_d       = (cnt_d == BURST_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            raddr_q      <= '0;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            pending_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            sequencing_q <= 1'b0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            raddr_q      <= raddr_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            pending_q    <= pending_d;
            rd_vld_q     <= rd_vld_d;
            rd_first_q   <= rd_first_d;
            rd_last_q    <= rd_last_d;
            sequencing_q <= sequencing_d;
            full_q       <= full_d;
            overrun_q    <= overrun_d;
        end
    end

    assign we         = wrt_smpl;
    assign waddr      = wr_ptr_q;
    assign raddr      = raddr_q;
    assign rd_vld     = rd_vld_q;
    assign rd_first   = rd_first_q;
    assign rd_last    = rd_last_q;
    assign sequencing = sequencing_q;
    assign full       = full_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_hifq_seq_ctrl.sv
// Directed bench for hifq_seq_ctrl with DEPTH=8, BURST=5: fill, sliding window, wrap,
// queued bursts, overrun and mid-burst reset.
module tb_hifq_seq_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int BURST = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wrt_smpl = 1'b0;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          rd_vld;
    logic          rd_first;
    logic          rd_last;
    logic          sequencing;
    logic          full;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    hifq_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .BURST(BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .we         (we),
        .waddr      (waddr),
        .raddr      (raddr),
        .rd_vld     (rd_vld),
        .rd_first   (rd_first),
        .rd_last    (rd_last),
        .sequencing (sequencing),
        .full       (full),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_raddr"}, 32'(raddr), 0);
        chk({tag, "_vld"},   32'(rd_vld), 0);
        chk({tag, "_first"}, 32'(rd_first), 0);
        chk({tag, "_last"},  32'(rd_last), 0);
        chk({tag, "_seq"},   32'(sequencing), 0);
        chk({tag, "_full"},  32'(full), 0);
        chk({tag, "_ovr"},   32'(overrun), 0);
    endtask

    // One-cycle write pulse; checks the write port in the strobe cycle
    task automatic wr(input string tag, input int exp_addr);
        wrt_smpl = 1'b1;
        chk({tag, "_we"},    32'(we), 1);
        chk({tag, "_waddr"}, 32'(waddr), 32'(exp_addr));
        tick();
        wrt_smpl = 1'b0;
    endtask

    // Entered in the first SEQ cycle (T+1); leaves at T+BURST+2.
    // inj[k] drives wrt_smpl in cycle T+1+k (k==BURST is the drain cycle).
    task automatic burst(input string tag, input int start, input logic [7:0] inj,
                         input bit chain, input logic exp_ov);
        for (int k = 0; k <= BURST; k++) begin
            wrt_smpl = inj[k];
            chk({tag, "_seq"},   32'(sequencing), 1);
            chk({tag, "_vld"},   32'(rd_vld), (k >= 1) ? 1 : 0);
            chk({tag, "_first"}, 32'(rd_first), (k == 1) ? 1 : 0);
            chk({tag, "_last"},  32'(rd_last), (k == BURST) ? 1 : 0);
            if (k < BURST) chk({tag, "_raddr"}, 32'(raddr), 32'((start + k) % DEPTH));
            tick();
        end
        wrt_smpl = 1'b0;
        chk({tag, "_after_seq"}, 32'(sequencing), chain ? 1 : 0);
        chk({tag, "_gap_vld"},   32'(rd_vld), 0);
        chk({tag, "_ovr"},       32'(overrun), 32'(exp_ov));
    endtask

    initial begin
        // Reset state
        #2;
        chk_all_zero("rst");
        tick();
        tick();
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        tick();
        chk_all_zero("rst_rel");

        // Fill: no burst until the fifth sample
        for (int i = 0; i < 4; i++) begin
            wr("fill", i);
            chk("fill_seq",  32'(sequencing), 0);
            chk("fill_full", 32'(full), 0);
        end
        wr("fill5", 4);
        chk("fill5_full", 32'(full), 1);
        burst("b0", 0, 8'h00, 1'b0, 1'b0);

        // Sliding window and wrap
        wr("w6", 5);
        burst("b1", 1, 8'h00, 1'b0, 1'b0);
        wr("w7", 6);
        burst("b2", 2, 8'h00, 1'b0, 1'b0);
        wr("w8", 7);
        chk("w8_ptr_wrap", 32'(waddr), 0);
        burst("b3", 3, 8'h00, 1'b0, 1'b0);
        wr("w9", 0);
        burst("wrap", 4, 8'h00, 1'b0, 1'b0);

        // One queued request during SEQ
        wr("w10", 1);
        burst("pend", 5, 8'b0000_0100, 1'b1, 1'b0);
        chk("pend_ptr", 32'(waddr), 3);
        burst("pend2", 6, 8'h00, 1'b0, 1'b0);

        // Two requests in one SEQ: overrun, single queued burst
        wr("w12", 3);
        burst("ovr", 7, 8'b0000_1010, 1'b1, 1'b1);
        burst("ovr2", 1, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovr_idle_seq", 32'(sequencing), 0);
        end
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_ptr", 32'(waddr), 6);

        // Request arriving in the drain cycle
        wr("w15", 6);
        burst("drn", 2, 8'b0010_0000, 1'b1, 1'b1);
        burst("drn2", 3, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a burst
        wr("w17", 0);
        tick();
        chk("mid_vld", 32'(rd_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick();
        tick();
        chk("mid_hold_vld", 32'(rd_vld), 0);
        rst_n = 1'b1;
        tick();
        chk_all_zero("mid_rel");
        tick();
        chk("mid_rel_vld", 32'(rd_vld), 0);

        // Back in FILL: needs a full refill before bursting again
        for (int i = 0; i < 4; i++) begin
            wr("refill", i);
            chk("refill_seq", 32'(sequencing), 0);
        end
        wr("refill5", 4);
        burst("rb", 0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
